// File: rtl/apb_master_q.sv
// APB requester fed from a small command FIFO. Each queued command becomes one
// SETUP/ACCESS transfer and ends in a one-cycle response pulse, or a timeout abort.
module apb_master_q #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned EntW     = 1 + ADDR_W + DATA_W + StrbW;
  localparam int unsigned WaitW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned WaitLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [EntW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ready_q, ready_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [StrbW-1:0]  pstrb_q, pstrb_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic              push, pop, queue_empty, done, timed_out;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [StrbW-1:0]  head_strb;

  assign push        = cmd_valid_i & ready_q;
  assign queue_empty = (count_q == '0);
  assign {head_write, head_addr, head_wdata, head_strb} = mem_q[rd_ptr_q];

  // Storage needs no reset: entries are only read once count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pop       = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!queue_empty) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // A ready completer wins over a timeout landing in the same cycle.
        if (pready_i) begin
          done = 1'b1;
        end else if ((TIMEOUT > 0) && (wait_q == WaitW'(WaitLast))) begin
          timed_out = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
        if (done || timed_out) begin
          if (!queue_empty) begin
            pop     = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      wait_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Ready follows the post-edge occupancy only, so a pop never unblocks a full queue early.
    ready_d = (count_d != CntW'(DEPTH));
  end

  always_comb begin
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    if (pop) begin
      pwrite_d = head_write;
      paddr_d  = head_addr;
      pwdata_d = head_wdata;
      pstrb_d  = head_write ? head_strb : '0;
    end
    if (done) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
      rsp_err_d     = pslverr_i;
      rsp_timeout_d = 1'b0;
    end else if (timed_out) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      wait_q        <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      wait_q        <= wait_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = ready_q;
  assign psel_o        = (state_q != StIdle);
  assign penable_o     = (state_q == StAccess);
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_q.sv
// Bench for apb_master_q: directed and random commands, a completer that follows a
// per-transfer wait plan, and a transaction-level model predicting bus phases and responses.
module tb_apb_master_q;

  localparam int Depth = 4;
  localparam int Tmo   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;
  logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;

  apb_master_q #(.ADDR_W(32), .DATA_W(32), .DEPTH(Depth), .TIMEOUT(Tmo)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command plus how the completer should answer it.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } tx_t;

  typedef enum int {PhIdle, PhSetup, PhAccess} phase_e;

  tx_t    tx_q[$];
  tx_t    cur;
  phase_e ph       = PhIdle;
  int     occ      = 0;
  int     acc      = 0;
  int     dur      = 0;
  bit     pend     = 1'b0;
  bit     due      = 1'b0;
  bit     have_cur = 1'b0;

  // Transfer length in ACCESS cycles: waits+1, or the timeout limit if the completer never answers.
  function automatic int dur_of(input int waits);
    return (waits >= Tmo) ? Tmo : waits + 1;
  endfunction

  // Completer and checker: works mid-cycle on what the last rising edge produced.
  initial begin
    pready_i  = 1'b0;
    prdata_i  = '0;
    pslverr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ph = PhIdle; occ = 0; acc = 0; pend = 1'b0; due = 1'b0; have_cur = 1'b0;
        pready_i = 1'b0;
      end else begin
        due = 1'b0;
        case (ph)
          PhIdle:   if (occ > 0) begin ph = PhSetup; occ--; end
          PhSetup:  begin ph = PhAccess; acc = 1; end
          PhAccess: begin
            if (acc == dur) begin
              due = 1'b1;
              if (occ > 0) begin ph = PhSetup; occ--; end
              else ph = PhIdle;
            end else begin
              acc++;
            end
          end
          default:  ph = PhIdle;
        endcase
        occ += int'(pend);
        pend = cmd_valid_i && cmd_ready_o;

        chk("psel", psel_o, ph != PhIdle);
        chk("penable", penable_o, ph == PhAccess);
        chk("rsp_valid", rsp_valid_o, due);
        chk("cmd_ready", cmd_ready_o, occ < Depth);
        if (due) begin
          bit to;
          to = (cur.waits >= Tmo);
          chk("rsp_timeout", rsp_timeout_o, to);
          chk("rsp_err", rsp_err_o, to ? 1'b1 : cur.err);
          chk("rsp_rdata", rsp_rdata_o, (to || cur.wr) ? 32'h0 : cur.rdata);
        end

        if (ph == PhSetup) begin
          if (tx_q.size() > 0) cur = tx_q.pop_front();
          else cur = '{default: 0};
          have_cur = 1'b1;
          dur = dur_of(cur.waits);
          chk("setup_paddr", paddr_o, cur.addr);
          chk("setup_pwrite", pwrite_o, cur.wr);
          chk("setup_pwdata", pwdata_o, cur.wdata);
          chk("setup_pstrb", pstrb_o, cur.wr ? cur.strb : 4'h0);
          pready_i = 1'b0;
        end else if (ph == PhAccess) begin
          chk("access_paddr", paddr_o, cur.addr);
          chk("access_ctl", {pwrite_o, pstrb_o, pwdata_o},
              {cur.wr, cur.wr ? cur.strb : 4'h0, cur.wdata});
          pready_i  = (acc > cur.waits);
          prdata_i  = cur.rdata;
          pslverr_i = cur.err;
        end else begin
          if (have_cur) begin
            chk("idle_hold_paddr", paddr_o, cur.addr);
            chk("idle_hold_pstrb", pstrb_o, cur.wr ? cur.strb : 4'h0);
          end
          pready_i  = 1'b0;
          prdata_i  = $urandom;
          pslverr_i = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input bit err,
                      input logic [31:0] rdata);
    tx_t t;
    bit  took;
    int  n;
    t = '{wr: wr, addr: addr, wdata: wdata, strb: strb, waits: waits, err: err, rdata: rdata};
    tx_q.push_back(t);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    took = 1'b0;
    n = 0;
    while (!took && n < 200) begin
      took = cmd_ready_o;
      step();
      n++;
    end
    cmd_valid_i = 1'b0;
    chk("push_accept", took, 1'b1);
  endtask

  task automatic drain();
    bit quiet;
    int n;
    n = 0;
    quiet = 1'b0;
    while (!quiet && n < 600) begin
      step();
      quiet = (ph == PhIdle) && (occ == 0) && !pend && (tx_q.size() == 0);
      n++;
    end
    chk("drain", quiet, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    #1 reset = 1'b0;
    repeat (2) step();
    chk("rst_psel", psel_o, 1'b0);
    chk("rst_penable", penable_o, 1'b0);
    chk("rst_pwrite", pwrite_o, 1'b0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_pstrb", pstrb_o, 4'h0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    chk("rst_cmd_ready", cmd_ready_o, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    step();
    chk("ready_after_reset", cmd_ready_o, 1'b1);

    // Single write, immediate completion.
    push(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0);
    drain();
    // Read with three wait states.
    push(1'b0, 32'h20, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0000_00C3);
    drain();

    // Fill the queue behind a stalled transfer, then one more that must wait.
    push(1'b1, 32'h100, 32'h1111_1111, 4'h3, 12, 1'b0, 32'h0);
    push(1'b0, 32'h104, 32'h0, 4'hF, 0, 1'b0, 32'h2222_2222);
    push(1'b1, 32'h108, 32'h3333_3333, 4'hC, 1, 1'b0, 32'h0);
    push(1'b0, 32'h10C, 32'h0, 4'h0, 2, 1'b1, 32'h4444_4444);
    push(1'b1, 32'h110, 32'h5555_5555, 4'h1, 0, 1'b0, 32'h0);
    chk("full_ready", cmd_ready_o, 1'b0);
    push(1'b0, 32'h114, 32'h0, 4'h0, 0, 1'b0, 32'h6666_6666);
    drain();

    // Timeout, then boundary: ready on the last allowed cycle, then a long stall.
    push(1'b1, 32'h200, 32'h7777_7777, 4'hF, 16, 1'b0, 32'h0);
    push(1'b0, 32'h204, 32'h0, 4'hF, 0, 1'b0, 32'h8888_8888);
    push(1'b0, 32'h208, 32'h0, 4'hF, 15, 1'b0, 32'h9999_9999);
    push(1'b0, 32'h20C, 32'h0, 4'hF, 40, 1'b0, 32'hAAAA_AAAA);
    drain();

    // Slave error on write and read.
    push(1'b1, 32'h300, 32'hBBBB_BBBB, 4'h5, 1, 1'b1, 32'h0);
    push(1'b0, 32'h304, 32'h0, 4'hF, 0, 1'b1, 32'hCCCC_CCCC);
    drain();

    // Random traffic with random gaps.
    for (int i = 0; i < 30; i++) begin
      int r, w;
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? r : (r == 7) ? 15 : (r == 8) ? 16 : int'($urandom_range(17, 25));
      repeat ($urandom_range(0, 3)) step();
      push(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
           4'($urandom_range(0, 15)), w, ($urandom_range(0, 3) == 0), $urandom);
    end
    drain();

    // Reset in ACCESS with two commands still queued.
    push(1'b1, 32'h400, 32'hDDDD_DDDD, 4'hF, 40, 1'b0, 32'h0);
    push(1'b0, 32'h404, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678);
    push(1'b1, 32'h408, 32'hEEEE_EEEE, 4'hF, 0, 1'b0, 32'h0);
    begin
      bit ready_state;
      int n;
      n = 0;
      ready_state = 1'b0;
      while (!ready_state && n < 20) begin
        ready_state = (ph == PhAccess) && (occ == 2);
        if (!ready_state) step();
        n++;
      end
      chk("rst_in_access", ready_state, 1'b1);
    end
    reset = 1'b0;
    #1;
    chk("midrst_psel", psel_o, 1'b0);
    chk("midrst_penable", penable_o, 1'b0);
    chk("midrst_cmd_ready", cmd_ready_o, 1'b0);
    chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
    tx_q.delete();
    repeat (2) step();
    @(negedge clk);
    #1 reset = 1'b1;
    step();
    chk("midrst_ready_after", cmd_ready_o, 1'b1);
    repeat (8) step();
    chk("midrst_queue_empty", psel_o, 1'b0);
    push(1'b0, 32'h500, 32'h0, 4'hF, 2, 1'b0, 32'h0BAD_F00D);
    drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
